// File: rtl/sign_input_router_if.sv
// Host word stream and tagged field stream between the sign port and datapath.
interface sign_input_router_if #(
   parameter int W      = 64,
   parameter int ADDR_W = 10
);
   logic              valid_i;
   logic              ready_i;
   logic [W-1:0]      data_i;
   logic              fld_valid;
   logic              fld_ready;
   logic [2:0]        fld_sel;
   logic [ADDR_W-1:0] fld_addr;
   logic [W-1:0]      fld_data;

   modport master (
      output valid_i, data_i, fld_ready,
      input  ready_i, fld_valid, fld_sel, fld_addr, fld_data
   );

   modport slave (
      input  valid_i, data_i, fld_ready,
      output ready_i, fld_valid, fld_sel, fld_addr, fld_data
   );
endinterface

// File: rtl/sign_input_router.sv
// Signing-mode input router: tags host words by field and index.
// Optional protocol checker: SIGN_INPUT_ROUTER_PROTO_CHECK_EN.
module sign_input_router #(
   parameter int W             = 64,
   parameter int HIGH_PERF     = 1,
   parameter int SEED_WORDS    = 4,
   parameter int S1_WORDS      = 48,
   parameter int S2_WORDS      = 48,
   parameter int T0_WORDS      = 208,
   parameter int ADDR_W        = 10,
   parameter int MAX_MSG_WORDS = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   sign_input_router_if.slave  bus,
   output logic [31:0]         mlen_o,
   output logic                busy,
   output logic                done,
   output logic                err
);
   typedef enum logic [3:0] {
      S_IDLE, S_RHO, S_MLEN, S_TR, S_MSG,
      S_K, S_S1, S_S2, S_T0, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ctr_q, ctr_d;
   logic [ADDR_W-1:0] msg_words_q, msg_words_d;
   logic [31:0]       mlen_q, mlen_d;

   logic              load;
   logic              acc;
   logic [2:0]        tag;
   logic [ADDR_W-1:0] fld_len;
   logic [ADDR_W-1:0] msg_calc;
   logic [34:0]       bits_w, q_w, words_w;
   logic              rem_w, ovf_w;

   function automatic state_t nxt(input state_t s);
      state_t n;
      n = S_DONE;
      if (HIGH_PERF != 0) begin
         unique case (s)
            S_RHO:   n = S_MLEN;
            S_MLEN:  n = S_TR;
            S_TR:    n = S_MSG;
            S_MSG:   n = S_K;
            S_K:     n = S_S1;
            S_S1:    n = S_S2;
            S_S2:    n = S_T0;
            default: n = S_DONE;
         endcase
      end else begin
         unique case (s)
            S_RHO:   n = S_K;
            S_K:     n = S_TR;
            S_TR:    n = S_S1;
            S_S1:    n = S_S2;
            S_S2:    n = S_T0;
            S_T0:    n = S_MLEN;
            S_MLEN:  n = S_MSG;
            default: n = S_DONE;
         endcase
      end
      return n;
   endfunction

   // Byte length to word count, rounded up; 35 bits cannot overflow
   assign bits_w  = {bus.data_i[31:0], 3'b000};
   assign q_w     = bits_w / 35'(W);
   assign rem_w   = (bits_w % 35'(W)) != 35'd0;
   assign words_w = q_w + 35'(rem_w);
   assign ovf_w   = words_w > 35'(MAX_MSG_WORDS);

   always_comb begin
      msg_calc = ADDR_W'(words_w);
      if (ovf_w) msg_calc = ADDR_W'(MAX_MSG_WORDS);
      else if (words_w == 35'd0) msg_calc = ADDR_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      mlen_d      = mlen_q;
      msg_words_d = msg_words_q;
      load        = 1'b0;
      tag         = 3'd0;
      fld_len     = ADDR_W'(1);
      unique case (state_q)
         S_IDLE: if (start) state_d = S_RHO;
         S_RHO: begin
            load = 1'b1; tag = 3'd0; fld_len = ADDR_W'(SEED_WORDS);
         end
         S_MLEN: begin
            load = 1'b1; tag = 3'd1; fld_len = ADDR_W'(1);
         end
         S_TR: begin
            load = 1'b1; tag = 3'd2; fld_len = ADDR_W'(SEED_WORDS);
         end
         S_MSG: begin
            load = 1'b1; tag = 3'd3; fld_len = msg_words_q;
         end
         S_K: begin
            load = 1'b1; tag = 3'd4; fld_len = ADDR_W'(SEED_WORDS);
         end
         S_S1: begin
            load = 1'b1; tag = 3'd5; fld_len = ADDR_W'(S1_WORDS);
         end
         S_S2: begin
            load = 1'b1; tag = 3'd6; fld_len = ADDR_W'(S2_WORDS);
         end
         S_T0: begin
            load = 1'b1; tag = 3'd7; fld_len = ADDR_W'(T0_WORDS);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      acc = load & bus.valid_i & bus.fld_ready;
      if (acc) begin
         if (ctr_q == fld_len - ADDR_W'(1)) begin
            ctr_d   = '0;
            state_d = nxt(state_q);
         end else begin
            ctr_d = ctr_q + ADDR_W'(1);
         end
         if (state_q == S_MLEN) begin
            mlen_d      = bus.data_i[31:0];
            msg_words_d = msg_calc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ctr_q       <= '0;
         mlen_q      <= '0;
         msg_words_q <= '0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         mlen_q      <= mlen_d;
         msg_words_q <= msg_words_d;
      end
   end

   assign bus.fld_valid = load & bus.valid_i;
   assign bus.ready_i   = load & bus.fld_ready;
   assign bus.fld_sel   = tag;
   assign bus.fld_addr  = load ? ctr_q : '0;
   assign bus.fld_data  = bus.data_i;
   assign mlen_o        = mlen_q;
   assign busy          = load;
   assign done          = state_q == S_DONE;

`ifdef SIGN_INPUT_ROUTER_PROTO_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (bus.valid_i && (state_q == S_IDLE || state_q == S_DONE))
         err_d = 1'b1;
      if (start && load) err_d = 1'b1;
      if (acc && state_q == S_MLEN && ovf_w) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sign_input_router.sv
// Directed-vector bench for sign_input_router, both field orders.
`timescale 1ns/1ps
module tb_sign_input_router;
   localparam int W  = 64;
   localparam int AW = 10;

   typedef struct {
      bit          hp;
      logic [31:0] mlen;
      int          stall;
      int          exp_msgw;
      int          exp_total;
      bit          exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic valid = 1'b0;
   logic frdy = 1'b0;
   logic [W-1:0] data = '0;
   bit hp_sel = 1'b1;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sign_input_router_if #(.W(W), .ADDR_W(AW)) ia ();
   sign_input_router_if #(.W(W), .ADDR_W(AW)) ib ();

   assign ia.valid_i   = valid;
   assign ia.data_i    = data;
   assign ia.fld_ready = frdy;
   assign ib.valid_i   = valid;
   assign ib.data_i    = data;
   assign ib.fld_ready = frdy;

   logic [31:0] mlen_a, mlen_b;
   logic busy_a, busy_b, done_a, done_b, err_a, err_b;

   sign_input_router #(.W(W), .HIGH_PERF(1), .ADDR_W(AW)) u_hp (
      .clk(clk), .rst(rst), .start(start), .bus(ia.slave),
      .mlen_o(mlen_a), .busy(busy_a), .done(done_a), .err(err_a)
   );

   sign_input_router #(.W(W), .HIGH_PERF(0), .ADDR_W(AW)) u_lr (
      .clk(clk), .rst(rst), .start(start), .bus(ib.slave),
      .mlen_o(mlen_b), .busy(busy_b), .done(done_b), .err(err_b)
   );

   logic rdy_o, fv_o, busy_o, done_o, err_o;
   logic [2:0] sel_o;
   logic [AW-1:0] addr_o;
   logic [W-1:0] fd_o;
   logic [31:0] mlen_o;

   always_comb begin
      rdy_o  = hp_sel ? ia.ready_i   : ib.ready_i;
      fv_o   = hp_sel ? ia.fld_valid : ib.fld_valid;
      sel_o  = hp_sel ? ia.fld_sel   : ib.fld_sel;
      addr_o = hp_sel ? ia.fld_addr  : ib.fld_addr;
      fd_o   = hp_sel ? ia.fld_data  : ib.fld_data;
      mlen_o = hp_sel ? mlen_a : mlen_b;
      busy_o = hp_sel ? busy_a : busy_b;
      done_o = hp_sel ? done_a : done_b;
      err_o  = hp_sel ? err_a  : err_b;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic int tag_of(input bit hp, input int fi);
      int hpo[8];
      int lro[8];
      hpo = '{0, 1, 2, 3, 4, 5, 6, 7};
      lro = '{0, 4, 2, 5, 6, 7, 1, 3};
      return hp ? hpo[fi] : lro[fi];
   endfunction

   function automatic int cnt_of(input int tg, input int msgw);
      case (tg)
         1:       return 1;
         3:       return msgw;
         5:       return 48;
         6:       return 48;
         7:       return 208;
         default: return 4;
      endcase
   endfunction

   task automatic do_reset();
      valid = 1'b0; frdy = 1'b0; start = 1'b0; rst = 1'b0;
      @(negedge clk); #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ready", rdy_o, 0);
      chk("rst_fvalid", fv_o, 0);
      chk("rst_sel", sel_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_mlen", mlen_o, 0);
      chk("rst_err", err_o, 0);
      rst = 1'b1; frdy = 1'b1;
      @(negedge clk); #1;
      chk("idle_ready", rdy_o, 0);
      chk("idle_busy", busy_o, 0);
   endtask

   task automatic run_vec(input vec_t v, input int ab_fi, input int ab_wi);
      int fi, wi, acc, cyc, tg;
      bit seen, lost;
      fi = 0; wi = 0; acc = 0; cyc = 0; seen = 0; lost = 0;
      hp_sel = v.hp;
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!seen && !lost && cyc < 5000) begin
         if (fi == ab_fi && wi == ab_wi) return;
         tg = (fi < 8) ? tag_of(v.hp, fi) : 0;
         if (fi < 8) begin
            valid = (v.stall == 0) || ($urandom_range(0, 99) >= v.stall);
            frdy  = (v.stall == 0) || ($urandom_range(0, 99) >= v.stall);
         end else begin
            valid = 1'b0;
            frdy  = 1'b1;
         end
         data = {$urandom, $urandom};
         if (fi < 8 && tg == 1) data[31:0] = v.mlen;
         #1;
         if (done_o) begin
            seen = 1;
            chk("done_at_end", fi, 8);
            chk("accepted", acc, v.exp_total);
            chk("mlen_o", mlen_o, v.mlen);
            chk("busy_done", busy_o, 0);
            chk("ready_done", rdy_o, 0);
`ifdef SIGN_INPUT_ROUTER_PROTO_CHECK_EN
            chk("err_end", err_o, v.exp_err);
`else
            chk("err_end", err_o, 0);
`endif
         end else if (fi >= 8) begin
            chk("done_missing", done_o, 1);
            lost = 1;
         end else begin
            chk("busy", busy_o, 1);
            chk("sel", sel_o, tg);
            chk("addr", addr_o, wi);
            chk("ready", rdy_o, frdy);
            chk("fvalid", fv_o, valid);
            chk("fdata", fd_o, data);
            if (valid && rdy_o) begin
               acc++;
               wi++;
               if (wi == cnt_of(tg, v.exp_msgw)) begin
                  wi = 0;
                  fi++;
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (!seen && !lost) begin
         chk("timeout", 0, 1);
      end else if (seen) begin
         #1;
         chk("done_pulse", done_o, 0);
         chk("after_ready", rdy_o, 0);
      end
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{1'b1, 32'd33,    0,  5,    322,  1'b0};
      vecs[1] = '{1'b0, 32'd8,     0,  1,    318,  1'b0};
      vecs[2] = '{1'b1, 32'd0,     0,  1,    318,  1'b0};
      vecs[3] = '{1'b1, 32'd64,    50, 8,    325,  1'b0};
      vecs[4] = '{1'b0, 32'd100,   50, 13,   330,  1'b0};
      vecs[5] = '{1'b1, 32'd33,    50, 5,    322,  1'b0};
      vecs[6] = '{1'b0, 32'd1,     30, 1,    318,  1'b0};
      vecs[7] = '{1'b1, 32'd10000, 0,  1023, 1340, 1'b1};

      for (int i = 0; i < 8; i++) run_vec(vecs[i], -1, -1);

      // Reset while S1 word 20 is on the bus
      run_vec(vecs[0], 5, 20);
      valid = 1'b1; frdy = 1'b1; data = {$urandom, $urandom};
      #1;
      chk("s1_sel", sel_o, 5);
      chk("s1_addr", addr_o, 20);
      rst = 1'b0;
      #1;
      chk("mid_busy", busy_o, 0);
      chk("mid_ready", rdy_o, 0);
      chk("mid_fvalid", fv_o, 0);
      chk("mid_addr", addr_o, 0);
      chk("mid_mlen", mlen_o, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("post_busy", busy_o, 0);
      chk("post_ready", rdy_o, 0);
`ifdef SIGN_INPUT_ROUTER_PROTO_CHECK_EN
      chk("idle_valid_err", err_o, 1);
`endif
      valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; valid = 1'b1;
      #1;
      chk("restart_sel", sel_o, 0);
      chk("restart_addr", addr_o, 0);
      chk("restart_busy", busy_o, 1);
      chk("restart_ready", rdy_o, 1);
      valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
